if_fetch_ctrl: RTL

//  IF-stage fetch controller, directly downstream of the PRE_IF PC register.
//  - Issues instruction fetches for the current PC on an SRAM-like bus.
//  - Tracks outstanding requests and buffers returned instructions in order.
//  - Presents {pc, instr, adel} to ID with a valid/ready handshake.
//  - Drives preif_wr back to the PC register so the PC advances only on accepted fetches or redirects.

---
 rtl/if_fetch_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: issues fetches, queues responses in order,
// and hands {pc, instr, adel} to ID over a valid/ready handshake.
module if_fetch_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] preif_pc,
    output logic        preif_wr,
    input  logic        flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_adel,
    input  logic        id_ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_pc     [DEPTH];
    logic [31:0]   r_instr  [DEPTH];
    logic          r_adel   [DEPTH];
    logic          r_filled [DEPTH];
    logic [AW-1:0] r_alloc;
    logic [AW-1:0] r_fill;
    logic [AW-1:0] r_head;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_unf;
    logic [CW-1:0] r_cancel;

    logic [CW:0]   w_load;
    logic          w_space;
    logic          w_aligned;
    logic          w_acc_req;
    logic          w_mis_alloc;
    logic          w_alloc;
    logic          w_drop;
    logic          w_fill;
    logic          w_pop;

    // Request, allocation, fill and pop decisions for this cycle
    always_comb begin
        w_load      = {1'b0, r_occ} + {1'b0, r_cancel};
        w_space     = w_load < (CW+1)'(DEPTH);
        w_aligned   = preif_pc[1:0] == 2'b00;
        inst_req    = w_aligned && w_space && !flush && !rst;
        inst_addr   = preif_pc;
        w_acc_req   = inst_req && inst_addr_ok;
        w_mis_alloc = !w_aligned && w_space && (r_unf == '0)
                      && !flush && !rst;
        w_alloc     = w_acc_req || w_mis_alloc;
        preif_wr    = !rst && (flush || w_alloc);
        w_drop      = inst_data_ok && (r_cancel != '0);
        w_fill      = inst_data_ok && (r_cancel == '0) && !flush;
        if_valid    = r_filled[r_head] && !flush && !rst;
        if_pc       = rst ? 32'h0 : r_pc[r_head];
        if_instr    = rst ? 32'h0 : r_instr[r_head];
        if_adel     = rst ? 1'b0 : r_adel[r_head];
        w_pop       = if_valid && id_ready;
    end

    // Queue storage, pointers, occupancy and owed-response tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alloc  <= '0;
            r_fill   <= '0;
            r_head   <= '0;
            r_occ    <= '0;
            r_unf    <= '0;
            r_cancel <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]     <= '0;
                r_instr[i]  <= '0;
                r_adel[i]   <= 1'b0;
                r_filled[i] <= 1'b0;
            end
        end else if (flush) begin
            r_alloc  <= '0;
            r_fill   <= '0;
            r_head   <= '0;
            r_occ    <= '0;
            r_unf    <= '0;
            r_cancel <= r_cancel + r_unf - CW'(inst_data_ok);
            for (int i = 0; i < DEPTH; i++) begin
                r_filled[i] <= 1'b0;
            end
        end else begin
            if (w_acc_req) begin
                r_pc[r_alloc]     <= preif_pc;
                r_adel[r_alloc]   <= 1'b0;
                r_filled[r_alloc] <= 1'b0;
                r_alloc           <= r_alloc + AW'(1);
            end
            if (w_mis_alloc) begin
                r_pc[r_alloc]     <= preif_pc;
                r_instr[r_alloc]  <= 32'h0;
                r_adel[r_alloc]   <= 1'b1;
                r_filled[r_alloc] <= 1'b1;
                r_alloc           <= r_alloc + AW'(1);
                r_fill            <= r_fill + AW'(1);
            end
            if (w_fill) begin
                r_instr[r_fill]  <= inst_rdata;
                r_filled[r_fill] <= 1'b1;
                r_fill           <= r_fill + AW'(1);
            end
            if (w_pop) begin
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + AW'(1);
            end
            if (w_drop) begin
                r_cancel <= r_cancel - CW'(1);
            end
            r_occ <= r_occ + CW'(w_alloc) - CW'(w_pop);
            r_unf <= r_unf + CW'(w_acc_req) - CW'(w_fill);
        end
    end

    // A response with nothing owed and nothing outstanding is a bus error
    always_ff @(posedge clk) begin
        assert (rst || !inst_data_ok || r_cancel != '0 || r_unf != '0)
            else $error("if_fetch_ctrl: unexpected inst_data_ok");
    end
endmodule
